// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store controller and round-robin arbiter for the word-wide data memory
//
// Shares one 32-bit word memory (asynchronous read, write on the falling clock edge)
// between the core load/store port and the debug/loader port.
//   clk, rst                      : clock, asynchronous active-high reset
//   core_req/we/addr/size/unsigned/wdata -> core_done/err/rdata : byte-addressed core port
//   dbg_req/we/addr/wdata         -> dbg_done/err/rdata  : word-addressed debug port
//   mem_addr/wdata/we/re          -> memory,  mem_rdata <- memory
// Sub-word stores become read-modify-write; loads get lane extraction and extension.
// Misaligned, illegal-size and out-of-range accesses complete with err=1 and no memory access.

module dmem_ctrl #(
    parameter int DEPTH_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    input  logic [31:0] core_wdata,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [29:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_done,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        last_dbg;     // 1 when the debug port won the most recent grant
    logic        r_dbg;        // owner of the transaction in flight
    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    // Request selected in IDLE, normalised to a common shape for both ports
    logic        g_any;
    logic        g_dbg;
    logic        g_we;
    logic        g_uns;
    logic        g_err;
    logic [1:0]  g_size;
    logic [1:0]  g_lane;
    logic [29:0] g_waddr;
    logic [31:0] g_wdata;

    always_comb begin
        g_any = core_req | dbg_req;
        // Contention goes to whoever did not win last time
        if (core_req && dbg_req) g_dbg = ~last_dbg;
        else                     g_dbg = dbg_req;
        if (g_dbg) begin
            g_we    = dbg_we;
            g_size  = 2'b10;
            g_lane  = 2'b00;
            g_uns   = 1'b0;
            g_waddr = dbg_addr;
            g_wdata = dbg_wdata;
            g_err   = 32'(dbg_addr) >= DEPTH_U;
        end else begin
            g_we    = core_we;
            g_size  = core_size;
            g_lane  = core_addr[1:0];
            g_uns   = core_unsigned;
            g_waddr = core_addr[31:2];
            g_wdata = core_wdata;
            g_err   = (core_size == 2'b11)
                   || (core_size == 2'b01 && core_addr[0])
                   || (core_size == 2'b10 && core_addr[1:0] != 2'b00)
                   || (32'(core_addr[31:2]) >= DEPTH_U);
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] merged;

    always_comb begin
        case (r_lane)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   ld_val = {{24{ld_byte[7] & ~r_unsigned}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~r_unsigned}}, ld_half};
            default: ld_val = mem_rdata;
        endcase

        merged = mem_rdata;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0:    merged[7:0]   = r_wdata[7:0];
                2'd1:    merged[15:8]  = r_wdata[7:0];
                2'd2:    merged[23:16] = r_wdata[7:0];
                default: merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            merged[31:16] = r_wdata[15:0];
        end else begin
            merged[15:0]  = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_dbg   <= 1'b1;
            r_dbg      <= 1'b0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_rdata <= '0;
            dbg_done   <= 1'b0;
            dbg_err    <= 1'b0;
            dbg_rdata  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
        end else begin
            // Pulse-style outputs; set only on the transition that needs them
            core_done <= 1'b0;
            core_err  <= 1'b0;
            dbg_done  <= 1'b0;
            dbg_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (g_any) begin
                        last_dbg   <= g_dbg;
                        r_dbg      <= g_dbg;
                        r_we       <= g_we;
                        r_unsigned <= g_uns;
                        r_size     <= g_size;
                        r_lane     <= g_lane;
                        r_wdata    <= g_wdata;
                        if (g_err) begin
                            state     <= RESP;
                            core_done <= ~g_dbg;
                            core_err  <= ~g_dbg;
                            dbg_done  <= g_dbg;
                            dbg_err   <= g_dbg;
                        end else if (!g_we || g_size != 2'b10) begin
                            state    <= RD;
                            mem_re   <= 1'b1;
                            mem_addr <= g_waddr;
                        end else begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_addr  <= g_waddr;
                            mem_wdata <= g_wdata;
                        end
                    end
                end
                RD: begin
                    if (r_we) begin
                        // mem_wdata doubles as the merge register for the write cycle
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state <= RESP;
                        if (r_dbg) begin
                            dbg_rdata <= mem_rdata;
                            dbg_done  <= 1'b1;
                        end else begin
                            core_rdata <= ld_val;
                            core_done  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state     <= RESP;
                    core_done <= ~r_dbg;
                    dbg_done  <= r_dbg;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl: vector table, random ops vs reference model, corner sequences

module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_unsigned;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_size;
    logic        core_done, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [29:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_done, dbg_err;
    logic [31:0] dbg_rdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(512)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_size(core_size),
        .core_unsigned(core_unsigned), .core_wdata(core_wdata),
        .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Memory: asynchronous read, write on the falling edge
    logic [31:0] mem [0:511];
    logic        fill = 1'b0;
    assign mem_rdata = mem[mem_addr[8:0]];

    always @(negedge clk) begin
        if (fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i) * 32'h9E3779B9;
        end else if (mem_we) begin
            mem[mem_addr[8:0]] <= mem_wdata;
        end
    end

    // Reference memory image maintained by the transaction-level model
    logic [31:0] ref_mem [0:511];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of one access; updates ref_mem for successful stores
    function automatic void model(input logic dbg, input logic we, input logic [31:0] addr,
                                  input logic [1:0] size, input logic uns, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd, output int lat);
        int unsigned w, sh;
        logic [31:0] word, v, mask;
        w  = dbg ? addr : addr / 4;
        sh = dbg ? 0 : 8 * (addr % 4);
        if (dbg) err = (w >= 512);
        else     err = (size == 3) || (size == 1 && addr % 2 != 0) ||
                       (size == 2 && addr % 4 != 0) || (w >= 512);
        rd  = '0;
        lat = 1;
        if (err) return;
        word = ref_mem[w[8:0]];
        if (dbg) size = 2'd2;
        if (!we) begin
            lat = 2;
            if (size == 0) begin
                v = (word >> sh) & 32'hFF;
                if (!uns && v >= 128) v = v - 256;
            end else if (size == 1) begin
                v = (word >> sh) & 32'hFFFF;
                if (!uns && v >= 32768) v = v - 65536;
            end else begin
                v = word;
            end
            rd = v;
        end else if (size == 2) begin
            lat = 2;
            ref_mem[w[8:0]] = wd;
        end else begin
            lat  = 3;
            mask = (size == 0) ? 32'hFF : 32'hFFFF;
            ref_mem[w[8:0]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
        end
    endfunction

    // Issue one request on either port and measure edges from sampling to done
    task automatic do_op(input logic dbg, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output logic we_seen);
        @(negedge clk);
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr[29:0]; dbg_wdata = wd;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_size = size;
            core_unsigned = uns; core_wdata = wd;
        end
        lat = 0;
        we_seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            we_seen |= mem_we;
        end while (!(dbg ? dbg_done : core_done) && lat < 20);
        err = dbg ? dbg_err : core_err;
        rd  = dbg ? dbg_rdata : core_rdata;
        core_req = 1'b0;
        dbg_req  = 1'b0;
        @(posedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        logic [31:0] m4;
    } vec_t;

    vec_t tv [16];

    initial begin
        logic        err, e_err, we_seen, consec, prev_done;
        logic [31:0] rd, e_rd;
        int          lat, e_lat, nbad, cyc;
        logic [3:0]  order;
        int          ndone;
        logic        dbg, we, uns;
        logic [31:0] addr, wd;
        logic [1:0]  size;

        tv[0]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        2, 32'hDEADBEEF};
        tv[1]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2, 32'hDEADBEEF};
        tv[2]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344, 1'b0, 32'h0,        2, 32'h11223344};
        tv[3]  = '{1'b1, 32'h12, 2'd0, 1'b0, 32'h123456AA, 1'b0, 32'h0,        3, 32'h11AA3344};
        tv[4]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'h11AA3344, 2, 32'h11AA3344};
        tv[5]  = '{1'b1, 32'h10, 2'd1, 1'b0, 32'h7777BEEF, 1'b0, 32'h0,        3, 32'h11AABEEF};
        tv[6]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'h11AABEEF, 2, 32'h11AABEEF};
        tv[7]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'h80FF7F01, 1'b0, 32'h0,        2, 32'h80FF7F01};
        tv[8]  = '{1'b0, 32'h11, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0000007F, 2, 32'h80FF7F01};
        tv[9]  = '{1'b0, 32'h12, 2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 2, 32'h80FF7F01};
        tv[10] = '{1'b0, 32'h12, 2'd1, 1'b1, 32'h0,        1'b0, 32'h000080FF, 2, 32'h80FF7F01};
        tv[11] = '{1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFF80FF, 2, 32'h80FF7F01};
        tv[12] = '{1'b0, 32'h13, 2'd1, 1'b0, 32'h0,        1'b1, 32'h0,        1, 32'h80FF7F01};
        tv[13] = '{1'b1, 32'h800, 2'd2, 1'b0, 32'h55555555, 1'b1, 32'h0,       1, 32'h80FF7F01};
        tv[14] = '{1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        1'b1, 32'h0,        1, 32'h80FF7F01};
        tv[15] = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        1'b0, 32'h00000080, 2, 32'h80FF7F01};

        for (int i = 0; i < 512; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9;

        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_size = 0; core_unsigned = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        fill = 1'b1;
        repeat (2) @(negedge clk);
        fill = 1'b0;
        chk("reset_ctrl", 32'({core_done, core_err, dbg_done, dbg_err, mem_we, mem_re}), 32'h0);
        chk("reset_data", core_rdata | dbg_rdata | mem_wdata | 32'(mem_addr), 32'h0);
        rst = 1'b0;

        // Directed vector table on the core port
        for (int i = 0; i < 16; i++) begin
            do_op(1'b0, tv[i].we, tv[i].addr, tv[i].size, tv[i].uns, tv[i].wd, err, rd, lat, we_seen);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tv[i].err));
            chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_word4", i), mem[4], tv[i].m4);
            if (!tv[i].we && !tv[i].err) chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
            if (tv[i].err) chk($sformatf("vec%0d_no_write", i), 32'(we_seen), 32'h0);
        end
        ref_mem[4] = 32'h80FF7F01;

        // Random traffic on both ports against the model
        for (int i = 0; i < 250; i++) begin
            dbg  = ($urandom_range(0, 3) == 0);
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            wd   = $urandom;
            addr = dbg ? 32'($urandom_range(0, 560)) : 32'($urandom_range(0, 2240));
            model(dbg, we, addr, size, uns, wd, e_err, e_rd, e_lat);
            do_op(dbg, we, addr, size, uns, wd, err, rd, lat, we_seen);
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d_lat", i), lat, e_lat);
            if (!we && !e_err) chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
            if (e_err) chk($sformatf("rnd%0d_no_write", i), 32'(we_seen), 32'h0);
        end

        // Arbitration: both requests held from reset
        @(negedge clk);
        rst = 1'b1;
        core_req = 1; core_we = 0; core_addr = 32'h10; core_size = 2'd2;
        dbg_req = 1; dbg_we = 0; dbg_addr = 30'd4;
        @(negedge clk);
        rst = 1'b0;
        order = 4'b0; ndone = 0; consec = 0; prev_done = 0; cyc = 0;
        while (ndone < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (core_done && dbg_done) consec = 1'b1;
            if ((core_done || dbg_done) && prev_done) consec = 1'b1;
            if (core_done || dbg_done) begin
                order = {order[2:0], dbg_done};
                ndone++;
            end
            prev_done = core_done | dbg_done;
        end
        core_req = 0; dbg_req = 0;
        chk("arb_count", ndone, 4);
        chk("arb_order", 32'(order), 32'b0101);
        chk("arb_single_pulse", 32'(consec), 32'h0);
        chk("arb_dbg_rdata", dbg_rdata, ref_mem[4]);
        chk("arb_core_rdata", core_rdata, ref_mem[4]);
        repeat (2) @(posedge clk);

        // Reset asserted during the read cycle of a byte store
        @(negedge clk);
        core_req = 1; core_we = 1; core_addr = 32'h15; core_size = 2'd0; core_wdata = 32'h5A;
        @(posedge clk);
        #1;
        chk("rmw_read_cycle", 32'(mem_re), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 32'({core_done, core_err, dbg_done, dbg_err, mem_we, mem_re}), 32'h0);
        chk("midrst_data", core_rdata | dbg_rdata | mem_wdata | 32'(mem_addr), 32'h0);
        core_req = 0;
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            we_seen |= mem_we;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_no_write", 32'(we_seen), 32'h0);
        chk("midrst_word5", mem[5], ref_mem[5]);
        do_op(1'b0, 1'b0, 32'h14, 2'd2, 1'b0, 32'h0, err, rd, lat, we_seen);
        chk("postrst_err", 32'(err), 32'h0);
        chk("postrst_lat", lat, 2);
        chk("postrst_rdata", rd, ref_mem[5]);

        nbad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("final_mem_mismatches", nbad, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Load/store controller and arbiter in front of the word-wide data memory (30-bit word address, 32-bit data, word write enable, asynchronous read, write on falling clock edge). It shares the memory between the core load/store port and a debug/loader port using round-robin arbitration. It converts byte and halfword stores into read-modify-write sequences and performs byte-lane extraction and sign extension for loads. It flags misaligned and out-of-range accesses without touching memory.

Parameters:
DEPTH_WORDS, 512, number of 32-bit words in the memory; any word address >= DEPTH_WORDS is out of range.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
core_req  input  1  core request; held stable until core_done
core_we  input  1  1=store, 0=load
core_addr  input  32  byte address
core_size  input  2  00 byte, 01 half, 10 word, 11 illegal
core_unsigned  input  1  load zero-extends when 1, sign-extends when 0
core_wdata  input  32  store data, right-aligned
core_done  output  1  one-cycle completion pulse
core_err  output  1  valid with core_done: misaligned, illegal size or out of range
core_rdata  output  32  load result, valid with core_done
dbg_req  input  1  debug request, word-only, held until dbg_done
dbg_we  input  1  1=store
dbg_addr  input  30  word address
dbg_wdata  input  32  store data
dbg_done  output  1  one-cycle completion pulse
dbg_err  output  1  out of range, valid with dbg_done
dbg_rdata  output  32  read word, valid with dbg_done
mem_addr  output  30  memory word address
mem_wdata  output  32  memory write data
mem_we  output  1  memory write enable
mem_re  output  1  memory read enable
mem_rdata  input  32  memory asynchronous read data

Behaviour:
- FSM states are IDLE, RD, WR and RESP. All request fields are registered at grant. Memory-side outputs are decoded from the state and the registered fields only.
- Reset (asynchronous) sets the state to IDLE and the last-grant register to DBG, so the core wins the first tie. All outputs go to 0 immediately, and mem_we drops in the same cycle even in mid-operation. No partial write completes after rst rises.
- Requests are sampled only in IDLE.
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted last is granted, and the last-grant register is updated.
- Next state from IDLE:
  - Error check fails: RESP with err=1. Errors are size=11, half with addr[0]=1, word with addr[1:0]!=0, or word address (core_addr[31:2] or dbg_addr) >= DEPTH_WORDS.
  - Load: RD.
  - Word store: WR.
  - Byte or half store: RD.
- RD state:
  - mem_re=1 and mem_addr=word address.
  - Load: the selected lane is extracted and extended into the rdata register.
    - Byte lane = addr[1:0].
    - Half lane = addr[1].
    - Sign- or zero-extended per core_unsigned.
    - Debug reads take the full word.
  - Sub-word store: mem_rdata is merged with the store data into the merge register. Only the target byte(s) are replaced, then the FSM goes to WR.
  - A load goes to RESP.
- WR state: mem_we=1, mem_addr=word address, mem_wdata=merged word (or wdata for a word store), then RESP.
- RESP state: done=1 for exactly one cycle to the granted requester, with rdata/err valid, then IDLE.
  - rdata holds its value until the next completion to that port.
  - err is 0 on success.
- Latency from the IDLE sampling edge to the done cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- The requester must drop req at the edge ending its done cycle. A req still high in the following IDLE is a new request.
- The non-granted requester waits with req held. No starvation: after any completion, a waiting requester is granted next.
- In all non-WR states, mem_we=0. mem_wdata=0 and mem_addr holds its last value outside RD/WR.

Test Plan:
- Word path: core word store 0xDEADBEEF to 0x00000010, then word load -> mem word 4 = 0xDEADBEEF, core_rdata=0xDEADBEEF, each done 2 cycles after sampling.
- Sub-word store: word 4 = 0x11223344; byte store 0xAA at 0x12 -> 0x11AA3344 in 3 cycles. Half store 0xBEEF at 0x10 -> 0x11AABEEF.
- Load extension: word 0x80FF7F01. Signed byte @+1 -> 0x0000007F; signed byte @+2 -> 0xFFFFFFFF; unsigned half @+2 -> 0x000080FF; signed half @+2 -> 0xFFFF80FF.
- Errors:
  - Half load at 0x13 -> core_err=1, done 1 cycle after sampling, mem_we never high.
  - Word store at 0x00000800 (word 512) -> core_err=1, mem_we never high.
  - size=11 -> core_err=1.
- Arbitration: core_req and dbg_req both held from reset -> grant order core, dbg, core, dbg. Each done is a single pulse, and no port is granted twice in a row while the other waits.
- Reset mid-operation: assert rst during the RD cycle of a byte store -> mem_we=0 throughout, target word unchanged, all outputs 0. After release, a fresh core load completes normally.
